spi_xfer_ctrl: RTL and testbench
================================

# spi_xfer_ctrl

Transfer sequencer between the SPI TX FIFO read port and the SPI shift engine. On a start command it frames chip select and pops words from the FIFO one at a time over the FIFO's req/resp/ack read handshake. Each word goes to the shifter over a valid/ready port, until a programmed burst count is reached, the FIFO runs dry in drain mode, or software aborts. It sits in the SPI core between the register block (command/status) and the FIFO/shifter datapath.

## Interface
- DATA_WIDTH, 16, FIFO/shifter word width
- CNT_WIDTH, 8, burst length and transfer counter width
- CS_SETUP, 2, cycles from cs_n_o low to first shifter word (≥1)
- CS_HOLD, 2, cycles from shifter idle to cs_n_o high (≥1)

Ports:
- clk_i  in  1  clock; single clock domain
- soft_rst_i  in  1  synchronous, active-high reset
- start_i  in  1  start pulse; ignored while busy_o=1
- burst_len_i  in  CNT_WIDTH  words per burst, sampled on accepted start; 0 means drain mode
- abort_i  in  1  stop after the word currently in flight
- busy_o  out  1  high from accepted start until done_o
- done_o  out  1  one-cycle pulse at end of burst
- xfer_cnt_o  out  CNT_WIDTH  words handed to the shifter in the current/last burst
- fifo_empty_i  in  1  FIFO empty flag
- fifo_req_o  out  1  FIFO read request, one-cycle pulse
- fifo_resp_i  in  1  FIFO read response
- fifo_data_i  in  DATA_WIDTH  FIFO read data, valid while fifo_resp_i=1
- fifo_ack_o  out  1  FIFO read acknowledge / pop, one-cycle pulse
- sh_valid_o  out  1  word valid to shifter
- sh_data_o  out  DATA_WIDTH  word to shifter
- sh_ready_i  in  1  shifter accepts word when sh_valid_o & sh_ready_i
- sh_idle_i  in  1  shifter has no word pending or shifting
- cs_n_o  out  1  SPI chip select, active low

## Operation
- All outputs registered. Reset values: busy_o=0, done_o=0, xfer_cnt_o=0, fifo_req_o=0, fifo_ack_o=0, sh_valid_o=0, sh_data_o=0, cs_n_o=1. State is IDLE, abort flag clear.
- IDLE: on start_i, latch burst_len_i, clear xfer_cnt_o, set busy_o, drive cs_n_o=0, load the setup counter, go to SETUP.
- SETUP: count CS_SETUP cycles, then go to CHECK.
- CHECK, in priority order:
  - abort flag set, or (burst_len≠0 and xfer_cnt=burst_len): go to DRAIN.
  - burst_len=0 and fifo_empty_i: go to DRAIN.
  - fifo_empty_i with burst_len≠0: stall in CHECK, cs_n_o held low.
  - otherwise: pulse fifo_req_o and go to WAIT_RESP.
- WAIT_RESP: on fifo_resp_i=1, latch fifo_data_i into sh_data_o and pulse fifo_ack_o next cycle (state ACK).
- ACK: go to SEND with sh_valid_o=1.
- SEND: hold sh_valid_o/sh_data_o until sh_ready_i. On handshake, drop sh_valid_o, xfer_cnt_o+1, go to GAP.
- GAP: one cycle so the FIFO flags reflect the pop, then go to CHECK.
- DRAIN: wait for sh_idle_i=1, then count CS_HOLD cycles, then cs_n_o=1, pulse done_o, clear busy_o, go to IDLE.
- abort_i is sampled in any non-IDLE state into a sticky flag, cleared on entry to IDLE. It never breaks an open FIFO handshake: an issued req always completes resp→ack→SEND.
- xfer_cnt_o wraps modulo 2^CNT_WIDTH. In drain mode the wrap is allowed; the burst continues until the FIFO is empty.
- soft_rst_i mid-burst: immediate return to reset values; cs_n_o goes high the next cycle.
- Unused state encodings recover to IDLE.

## Timing
- The start_i edge is cycle 0: cs_n_o=0 and busy_o=1 at cycle 1. First fifo_req_o at cycle 1+CS_SETUP.
- FIFO read, req in cycle t:
  - resp expected at t+1
  - fifo_ack_o at t+2
  - sh_valid_o from t+3
  - with sh_ready_i=1 at t+3, next req at t+5 (5-cycle word period at zero shifter backpressure).
- fifo_req_o and fifo_ack_o are never high for more than one cycle, and never high together.
- End of burst: once sh_idle_i=1 is seen in DRAIN, cs_n_o rises and done_o pulses CS_HOLD cycles later, in the same cycle. busy_o falls in that cycle.
- start_i coincident with done_o is ignored. A new start is accepted from the cycle after done_o.

## Test plan
- FIFO holds 3 words (0xA001, 0xA002, 0xA003), burst_len=3, shifter always ready -> exactly 3 req/ack pairs, shifter receives the words in order, xfer_cnt_o=3, done_o one pulse, cs_n_o low for the whole burst, FIFO empty after.
- burst_len=0 with 5 words in FIFO -> 5 words sent, DRAIN entered on fifo_empty_i, done_o pulses, xfer_cnt_o=5.
- burst_len=4 with only 2 words, then 2 more pushed 20 cycles later -> controller stalls in CHECK with cs_n_o=0, resumes, sends 4 words total, then done.
- sh_ready_i held low 10 cycles on word 2 -> sh_valid_o/sh_data_o stable throughout, no extra FIFO req, count still correct.
- abort_i pulsed in the cycle after fifo_req_o, burst_len=8 -> that word is still acked and sent, no further req, done_o pulses with xfer_cnt_o=1.
- soft_rst_i asserted in SEND -> next cycle all outputs at reset values, cs_n_o=1. A subsequent start runs a normal burst.

Source files
------------

// File: rtl/spi_xfer_ctrl.sv
// SPI transfer sequencer: frames chip select, pops TX FIFO words over a
// req/resp/ack handshake and hands them to the shift engine one at a time.
module spi_xfer_ctrl #(
  parameter int DATA_WIDTH = 16,
  parameter int CNT_WIDTH  = 8,
  parameter int CS_SETUP   = 2,
  parameter int CS_HOLD    = 2
) (
  input  logic                  clk_i,
  input  logic                  soft_rst_i,
  input  logic                  start_i,
  input  logic [CNT_WIDTH-1:0]  burst_len_i,
  input  logic                  abort_i,
  output logic                  busy_o,
  output logic                  done_o,
  output logic [CNT_WIDTH-1:0]  xfer_cnt_o,
  input  logic                  fifo_empty_i,
  output logic                  fifo_req_o,
  input  logic                  fifo_resp_i,
  input  logic [DATA_WIDTH-1:0] fifo_data_i,
  output logic                  fifo_ack_o,
  output logic                  sh_valid_o,
  output logic [DATA_WIDTH-1:0] sh_data_o,
  input  logic                  sh_ready_i,
  input  logic                  sh_idle_i,
  output logic                  cs_n_o
);

  localparam int TMR_MAX = (CS_SETUP > CS_HOLD) ? CS_SETUP : CS_HOLD;
  localparam int TW      = $clog2(TMR_MAX + 1);
  localparam logic [TW-1:0]         SETUP_LOAD = TW'(CS_SETUP - 1);
  localparam logic [TW-1:0]         HOLD_LOAD  = TW'(CS_HOLD - 1);
  localparam logic [TW-1:0]         TMR_ONE    = TW'(1);
  localparam logic [CNT_WIDTH-1:0]  CNT_ZERO   = {CNT_WIDTH{1'b0}};
  localparam logic [CNT_WIDTH-1:0]  CNT_ONE    = CNT_WIDTH'(1);
  localparam logic [DATA_WIDTH-1:0] DATA_ZERO  = {DATA_WIDTH{1'b0}};

  typedef enum logic [3:0] {
    S_IDLE      = 4'd0,
    S_SETUP     = 4'd1,
    S_CHECK     = 4'd2,
    S_WAIT_RESP = 4'd3,
    S_ACK       = 4'd4,
    S_SEND      = 4'd5,
    S_GAP       = 4'd6,
    S_DRAIN     = 4'd7,
    S_HOLD      = 4'd8
  } state_t;

  state_t                r_state, w_state, w_ck_state;
  logic [TW-1:0]         r_tmr, w_tmr;
  logic [CNT_WIDTH-1:0]  r_blen, w_blen;
  logic [CNT_WIDTH-1:0]  r_cnt, w_cnt;
  logic [DATA_WIDTH-1:0] r_data, w_data;
  logic                  r_abort, w_abort;
  logic                  r_busy, w_busy;
  logic                  r_done, w_done;
  logic                  r_req, w_req, w_ck_req;
  logic                  r_ack, w_ack;
  logic                  r_valid, w_valid;
  logic                  r_cs_n, w_cs_n;
  logic                  w_finish;

  // Fetch decision; the GAP cycle evaluates it too so the word period stays at five cycles
  always_comb begin
    w_ck_state = S_CHECK;
    w_ck_req   = 1'b0;
    if (r_abort || ((r_blen != CNT_ZERO) && (r_cnt == r_blen))) begin
      w_ck_state = S_DRAIN;
    end else if (fifo_empty_i) begin
      if (r_blen == CNT_ZERO) begin
        w_ck_state = S_DRAIN;
      end else begin
        w_ck_state = S_CHECK;
      end
    end else begin
      w_ck_state = S_WAIT_RESP;
      w_ck_req   = 1'b1;
    end
  end

  // Next-state and next-output logic
  always_comb begin
    w_state  = r_state;
    w_tmr    = r_tmr;
    w_blen   = r_blen;
    w_cnt    = r_cnt;
    w_data   = r_data;
    w_busy   = r_busy;
    w_done   = 1'b0;
    w_req    = 1'b0;
    w_ack    = 1'b0;
    w_valid  = r_valid;
    w_cs_n   = r_cs_n;
    w_finish = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (start_i && !r_done) begin
          w_blen = burst_len_i;
          w_cnt  = CNT_ZERO;
          w_busy = 1'b1;
          w_cs_n = 1'b0;
          if (CS_SETUP > 1) begin
            w_state = S_SETUP;
            w_tmr   = SETUP_LOAD;
          end else begin
            w_state = S_CHECK;
          end
        end else begin
          w_state = S_IDLE;
        end
      end
      S_SETUP: begin
        if (r_tmr <= TMR_ONE) begin
          w_state = S_CHECK;
        end else begin
          w_tmr = r_tmr - TMR_ONE;
        end
      end
      S_CHECK, S_GAP: begin
        w_state = w_ck_state;
        w_req   = w_ck_req;
      end
      S_WAIT_RESP: begin
        if (fifo_resp_i) begin
          w_data  = fifo_data_i;
          w_ack   = 1'b1;
          w_state = S_ACK;
        end else begin
          w_state = S_WAIT_RESP;
        end
      end
      S_ACK: begin
        w_valid = 1'b1;
        w_state = S_SEND;
      end
      S_SEND: begin
        if (sh_ready_i) begin
          w_valid = 1'b0;
          w_cnt   = r_cnt + CNT_ONE;
          w_state = S_GAP;
        end else begin
          w_state = S_SEND;
        end
      end
      S_DRAIN: begin
        if (sh_idle_i) begin
          if (CS_HOLD > 1) begin
            w_state = S_HOLD;
            w_tmr   = HOLD_LOAD;
          end else begin
            w_finish = 1'b1;
          end
        end else begin
          w_state = S_DRAIN;
        end
      end
      S_HOLD: begin
        if (r_tmr <= TMR_ONE) begin
          w_finish = 1'b1;
        end else begin
          w_tmr = r_tmr - TMR_ONE;
        end
      end
      default: begin
        w_state = S_IDLE;
        w_busy  = 1'b0;
        w_valid = 1'b0;
        w_cs_n  = 1'b1;
      end
    endcase
    if (w_finish) begin
      w_state = S_IDLE;
      w_cs_n  = 1'b1;
      w_done  = 1'b1;
      w_busy  = 1'b0;
    end else begin
      w_done  = 1'b0;
    end
  end

  // Sticky abort: only taken while a burst is running, dropped on return to idle
  always_comb begin
    if (w_state == S_IDLE) begin
      w_abort = 1'b0;
    end else if (r_state != S_IDLE) begin
      w_abort = r_abort | abort_i;
    end else begin
      w_abort = 1'b0;
    end
  end

  // State and registered outputs
  always_ff @(posedge clk_i) begin
    if (soft_rst_i) begin
      r_state <= S_IDLE;
      r_tmr   <= {TW{1'b0}};
      r_blen  <= CNT_ZERO;
      r_cnt   <= CNT_ZERO;
      r_data  <= DATA_ZERO;
      r_abort <= 1'b0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_req   <= 1'b0;
      r_ack   <= 1'b0;
      r_valid <= 1'b0;
      r_cs_n  <= 1'b1;
    end else begin
      r_state <= w_state;
      r_tmr   <= w_tmr;
      r_blen  <= w_blen;
      r_cnt   <= w_cnt;
      r_data  <= w_data;
      r_abort <= w_abort;
      r_busy  <= w_busy;
      r_done  <= w_done;
      r_req   <= w_req;
      r_ack   <= w_ack;
      r_valid <= w_valid;
      r_cs_n  <= w_cs_n;
    end
  end

  assign busy_o     = r_busy;
  assign done_o     = r_done;
  assign xfer_cnt_o = r_cnt;
  assign fifo_req_o = r_req;
  assign fifo_ack_o = r_ack;
  assign sh_valid_o = r_valid;
  assign sh_data_o  = r_data;
  assign cs_n_o     = r_cs_n;

endmodule

// File: tb/tb_spi_xfer_ctrl.sv
// Bench for spi_xfer_ctrl: behavioural FIFO and shifter models, a word
// scoreboard, a table of bursts and hand-written corner-case sequences.
module tb_spi_xfer_ctrl;

  logic        clk = 1'b0;
  logic        soft_rst, start, abort;
  logic [7:0]  blen;
  logic        fifo_empty, fifo_resp, sh_ready, sh_idle;
  logic [15:0] fifo_data;
  logic        busy_o, done_o, fifo_req_o, fifo_ack_o, sh_valid_o, cs_n_o;
  logic [7:0]  xfer_cnt_o;
  logic [15:0] sh_data_o;

  int vectors = 0;
  int miscompares = 0;
  logic [15:0] fq[$];
  logic [15:0] exp_q[$];
  int req_cnt, ack_cnt, done_cnt, words_rx, bp_word, bp_left, shift_cnt;
  logic req_d, prev_req, prev_ack, stall_prev;
  logic [15:0] stall_data;

  typedef struct {
    logic [7:0] blen;
    int         nwords;
    int         exp_cnt;
    int         exp_left;
  } vec_t;
  vec_t tbl[5];

  spi_xfer_ctrl #(.DATA_WIDTH(16), .CNT_WIDTH(8), .CS_SETUP(2), .CS_HOLD(2)) dut (
    .clk_i(clk), .soft_rst_i(soft_rst), .start_i(start), .burst_len_i(blen),
    .abort_i(abort), .busy_o(busy_o), .done_o(done_o), .xfer_cnt_o(xfer_cnt_o),
    .fifo_empty_i(fifo_empty), .fifo_req_o(fifo_req_o), .fifo_resp_i(fifo_resp),
    .fifo_data_i(fifo_data), .fifo_ack_o(fifo_ack_o), .sh_valid_o(sh_valid_o),
    .sh_data_o(sh_data_o), .sh_ready_i(sh_ready), .sh_idle_i(sh_idle), .cs_n_o(cs_n_o)
  );

  initial forever #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
    end
  endtask

  task automatic push(input logic [15:0] w);
    fq.push_back(w);
    exp_q.push_back(w);
  endtask

  task automatic clear();
    fq.delete();
    exp_q.delete();
    req_cnt = 0; ack_cnt = 0; done_cnt = 0; words_rx = 0;
  endtask

  task automatic do_start(input logic [7:0] len);
    @(negedge clk);
    blen  = len;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic chk_reset(input string nm);
    chk({nm, "_busy"},  32'(busy_o),     32'd0);
    chk({nm, "_done"},  32'(done_o),     32'd0);
    chk({nm, "_cnt"},   32'(xfer_cnt_o), 32'd0);
    chk({nm, "_req"},   32'(fifo_req_o), 32'd0);
    chk({nm, "_ack"},   32'(fifo_ack_o), 32'd0);
    chk({nm, "_valid"}, 32'(sh_valid_o), 32'd0);
    chk({nm, "_data"},  32'(sh_data_o),  32'd0);
    chk({nm, "_cs_n"},  32'(cs_n_o),     32'd1);
  endtask

  task automatic wait_done(input string nm, input bit poke, output int n);
    logic prev_cs;
    n = 0;
    prev_cs = cs_n_o;
    while (n < 500) begin
      @(negedge clk);
      n++;
      if (done_o) break;
      prev_cs = cs_n_o;
    end
    if (!done_o) begin
      chk({nm, "_done_timeout"}, 32'd0, 32'd1);
    end else begin
      chk({nm, "_done_cs_n"},    32'(cs_n_o),  32'd1);
      chk({nm, "_done_busy"},    32'(busy_o),  32'd0);
      chk({nm, "_pre_done_cs"},  32'(prev_cs), 32'd0);
      if (poke) begin
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk({nm, "_start_on_done_ignored"}, 32'(busy_o), 32'd0);
      end
    end
  endtask

  task automatic post_checks(input string nm, input int exp_cnt, input int exp_left);
    repeat (3) @(negedge clk);
    chk({nm, "_xfer_cnt"}, 32'(xfer_cnt_o), 32'(exp_cnt));
    chk({nm, "_reqs"},     32'(req_cnt),    32'(exp_cnt));
    chk({nm, "_acks"},     32'(ack_cnt),    32'(exp_cnt));
    chk({nm, "_words_rx"}, 32'(words_rx),   32'(exp_cnt));
    chk({nm, "_fifo_left"}, 32'(fq.size()), 32'(exp_left));
    chk({nm, "_done_pulses"}, 32'(done_cnt), 32'd1);
    chk({nm, "_idle_busy"}, 32'(busy_o), 32'd0);
    chk({nm, "_idle_cs_n"}, 32'(cs_n_o), 32'd1);
  endtask

  // FIFO / shifter models and protocol monitors, acting just after each falling edge
  initial begin
    fifo_empty = 1'b1; fifo_resp = 1'b0; fifo_data = 16'h0000;
    sh_ready = 1'b1; sh_idle = 1'b1;
    req_d = 1'b0; prev_req = 1'b0; prev_ack = 1'b0; stall_prev = 1'b0;
    stall_data = 16'h0000; shift_cnt = 0;
    forever begin
      @(negedge clk);
      #3;
      if (fifo_ack_o && fq.size() > 0) void'(fq.pop_front());
      fifo_resp  = req_d;
      fifo_data  = (req_d && fq.size() > 0) ? fq[0] : 16'h0000;
      req_d      = fifo_req_o;
      fifo_empty = (fq.size() == 0);
      if (fifo_req_o) req_cnt++;
      if (fifo_ack_o) ack_cnt++;
      if (done_o) done_cnt++;
      chk("req_ack_overlap", 32'(fifo_req_o & fifo_ack_o), 32'd0);
      chk("req_pulse_width", 32'(fifo_req_o & prev_req), 32'd0);
      chk("ack_pulse_width", 32'(fifo_ack_o & prev_ack), 32'd0);
      chk("cs_low_while_busy", 32'(busy_o & cs_n_o), 32'd0);
      prev_req = fifo_req_o;
      prev_ack = fifo_ack_o;
      if (sh_valid_o && words_rx == bp_word && bp_left > 0) begin
        if (stall_prev) chk("bp_data_stable", 32'(sh_data_o), 32'(stall_data));
        stall_prev = 1'b1;
        stall_data = sh_data_o;
        sh_ready   = 1'b0;
        bp_left--;
      end else begin
        if (stall_prev && bp_left > 0) chk("bp_valid_held", 32'(sh_valid_o), 32'd1);
        sh_ready   = 1'b1;
        stall_prev = 1'b0;
      end
      if (sh_valid_o && sh_ready) begin
        if (exp_q.size() == 0) chk("sb_underflow", 32'd1, 32'd0);
        else chk("sb_word", 32'(sh_data_o), 32'(exp_q.pop_front()));
        words_rx++;
        shift_cnt = 4;
      end else if (shift_cnt > 0) begin
        shift_cnt--;
      end
      sh_idle = (shift_cnt == 0) && !sh_valid_o;
    end
  end

  initial begin
    int n;
    soft_rst = 1'b1; start = 1'b0; abort = 1'b0; blen = 8'd0;
    bp_word = 0; bp_left = 0;
    clear();
    tbl[0] = '{8'd0, 5, 5, 0};
    tbl[1] = '{8'd2, 4, 2, 2};
    tbl[2] = '{8'd1, 1, 1, 0};
    tbl[3] = '{8'd0, 0, 0, 0};
    tbl[4] = '{8'd4, 4, 4, 0};

    repeat (3) @(negedge clk);
    chk_reset("reset");
    soft_rst = 1'b0;

    // Three-word burst with cycle-exact timing
    clear();
    push(16'hA001); push(16'hA002); push(16'hA003);
    @(negedge clk);
    blen = 8'd3; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("c1_cs_n", 32'(cs_n_o), 32'd0);
    chk("c1_busy", 32'(busy_o), 32'd1);
    chk("c1_req",  32'(fifo_req_o), 32'd0);
    @(negedge clk); chk("c2_req", 32'(fifo_req_o), 32'd0);
    @(negedge clk); chk("c3_req", 32'(fifo_req_o), 32'd1);
    @(negedge clk); chk("c4_req", 32'(fifo_req_o), 32'd0);
    chk("c4_ack", 32'(fifo_ack_o), 32'd0);
    @(negedge clk); chk("c5_ack", 32'(fifo_ack_o), 32'd1);
    chk("c5_valid", 32'(sh_valid_o), 32'd0);
    @(negedge clk); chk("c6_valid", 32'(sh_valid_o), 32'd1);
    chk("c6_data", 32'(sh_data_o), 32'h0000A001);
    @(negedge clk); chk("c7_valid", 32'(sh_valid_o), 32'd0);
    chk("c7_cnt", 32'(xfer_cnt_o), 32'd1);
    @(negedge clk); chk("c8_req", 32'(fifo_req_o), 32'd1);
    wait_done("t3w", 1'b0, n);
    chk("t3w_done_cycle", 32'(8 + n), 32'd22);
    post_checks("t3w", 3, 0);

    for (int i = 0; i < 5; i++) begin
      clear();
      for (int k = 0; k < tbl[i].nwords; k++) push(16'((i + 1) * 4096 + k + 1));
      do_start(tbl[i].blen);
      wait_done($sformatf("vec%0d", i), 1'b0, n);
      post_checks($sformatf("vec%0d", i), tbl[i].exp_cnt, tbl[i].exp_left);
    end

    // FIFO runs dry mid-burst, refilled 20 cycles later
    clear();
    push(16'hB001); push(16'hB002);
    do_start(8'd4);
    repeat (20) @(negedge clk);
    chk("stall_busy", 32'(busy_o), 32'd1);
    chk("stall_cs_n", 32'(cs_n_o), 32'd0);
    chk("stall_cnt",  32'(xfer_cnt_o), 32'd2);
    chk("stall_reqs", 32'(req_cnt), 32'd2);
    push(16'hB003); push(16'hB004);
    wait_done("stall", 1'b0, n);
    post_checks("stall", 4, 0);

    // Shifter back-pressure on the second word
    clear();
    bp_word = 1; bp_left = 10;
    push(16'hC001); push(16'hC002); push(16'hC003);
    do_start(8'd3);
    wait_done("bp", 1'b0, n);
    post_checks("bp", 3, 0);
    chk("bp_consumed", 32'(bp_left), 32'd0);

    // Abort one cycle after the first request
    clear();
    bp_left = 0;
    for (int k = 0; k < 8; k++) push(16'(16'hD001 + k));
    do_start(8'd8);
    n = 0;
    while (!fifo_req_o && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("abort_req_seen", 32'(fifo_req_o), 32'd1);
    @(negedge clk); abort = 1'b1;
    @(negedge clk); abort = 1'b0;
    wait_done("abort", 1'b0, n);
    post_checks("abort", 1, 7);

    // Start coincident with done is ignored
    clear();
    push(16'hE001);
    do_start(8'd1);
    wait_done("coin", 1'b1, n);
    post_checks("coin", 1, 0);

    // Soft reset while the controller waits in SEND
    clear();
    bp_word = 0; bp_left = 10;
    push(16'hF001); push(16'hF002); push(16'hF003);
    do_start(8'd3);
    n = 0;
    while (!sh_valid_o && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("srst_in_send", 32'(sh_valid_o), 32'd1);
    soft_rst = 1'b1;
    @(negedge clk);
    bp_left = 0;
    chk_reset("srst");
    soft_rst = 1'b0;
    repeat (3) @(negedge clk);
    chk("srst_stays_idle_cs", 32'(cs_n_o), 32'd1);
    chk("srst_stays_idle_req", 32'(req_cnt > 1 ? 1 : 0), 32'd0);
    clear();
    push(16'h5A01); push(16'h5A02);
    do_start(8'd2);
    wait_done("after_srst", 1'b0, n);
    post_checks("after_srst", 2, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
